// File: rtl/bip2_control_unit_pkg.sv
// Shared opcodes, ACC source encodings and FSM states for the BIP-2 control unit.
package bip2_control_unit_pkg;

  localparam int unsigned DataW  = 11;
  localparam int unsigned OpcW   = 5;
  localparam int unsigned InstrW = OpcW + DataW;

  localparam logic [OpcW-1:0] OpHlt  = 5'd0;
  localparam logic [OpcW-1:0] OpSto  = 5'd1;
  localparam logic [OpcW-1:0] OpLd   = 5'd2;
  localparam logic [OpcW-1:0] OpLdi  = 5'd3;
  localparam logic [OpcW-1:0] OpAdd  = 5'd4;
  localparam logic [OpcW-1:0] OpAddi = 5'd5;
  localparam logic [OpcW-1:0] OpSub  = 5'd6;
  localparam logic [OpcW-1:0] OpSubi = 5'd7;
  localparam logic [OpcW-1:0] OpBeq  = 5'd8;
  localparam logic [OpcW-1:0] OpBne  = 5'd9;
  localparam logic [OpcW-1:0] OpBgt  = 5'd10;
  localparam logic [OpcW-1:0] OpBge  = 5'd11;
  localparam logic [OpcW-1:0] OpBlt  = 5'd12;
  localparam logic [OpcW-1:0] OpBle  = 5'd13;
  localparam logic [OpcW-1:0] OpJmp  = 5'd14;

  localparam logic [1:0] AccSelAlu = 2'b00;
  localparam logic [1:0] AccSelMem = 2'b01;
  localparam logic [1:0] AccSelImm = 2'b10;

  typedef enum logic [2:0] {
    StRstWait,
    StFetch,
    StDecode,
    StMem,
    StExec,
    StHalt
  } state_e;

  function automatic logic is_arith(input logic [OpcW-1:0] opc);
    return opc inside {OpAdd, OpAddi, OpSub, OpSubi};
  endfunction

  // Opcodes that need a data-memory access before they can finish.
  function automatic logic is_mem_op(input logic [OpcW-1:0] opc);
    return opc inside {OpSto, OpLd, OpAdd, OpSub};
  endfunction

endpackage

// File: rtl/bip2_branch_eval.sv
// Branch resolution: decides taken/not-taken from the opcode and the {N,Z} STATUS register.
module bip2_branch_eval
  import bip2_control_unit_pkg::*;
(
  input  logic [OpcW-1:0] opcode_i,
  input  logic [1:0]      status_i,
  output logic            taken_o
);

  logic z, n;

  assign z = status_i[0];
  assign n = status_i[1];

  always_comb begin
    taken_o = 1'b0;
    case (opcode_i)
      OpBeq:   taken_o = z;
      OpBne:   taken_o = !z;
      OpBgt:   taken_o = !z && !n;
      OpBge:   taken_o = !n;
      OpBlt:   taken_o = n;
      OpBle:   taken_o = n || z;
      OpJmp:   taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bip2_control_unit.sv
// BIP-2 sequencer: fetch/decode/mem/exec FSM driving the ALU, ACC and memories.
// Define BIP2_STEP_EN to add a `step` input that gates each instruction fetch.
module bip2_control_unit
  import bip2_control_unit_pkg::*;
#(
  parameter int unsigned       DATA_W   = DataW,
  parameter int unsigned       OPC_W    = OpcW,
  parameter int unsigned       INSTR_W  = OPC_W + DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
`ifdef BIP2_STEP_EN
  input  logic               step,
`endif
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [DATA_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  input  logic               dmem_valid,
  output logic [DATA_W-1:0]  operand,
  output logic               alu_operation,
  output logic               alu_op2_sel,
  input  logic               alu_z,
  input  logic               alu_n,
  output logic               acc_we,
  output logic [1:0]         acc_sel,
  output logic [1:0]         status,
  output logic               halted
);

  localparam logic [DATA_W-1:0] PcOne = DATA_W'(1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [1:0]         status_q, status_d;
  logic [OPC_W-1:0]   opcode;
  logic [DATA_W-1:0]  operand_w;
  logic               taken;
  logic               fetch_go;

  assign opcode    = ir_q[INSTR_W-1 -: OPC_W];
  assign operand_w = ir_q[DATA_W-1:0];
  assign imem_addr = pc_q;
  assign dmem_addr = operand_w;
  assign operand   = operand_w;
  assign status    = status_q;

  bip2_branch_eval u_branch_eval (
    .opcode_i (opcode),
    .status_i (status_q),
    .taken_o  (taken)
  );

`ifdef BIP2_STEP_EN
  logic step_seen_q, step_seen_d;
  logic retire;

  // An instruction retires on the cycle the FSM heads back to FETCH.
  assign retire      = (state_q == StExec) ||
                       (state_q == StMem && dmem_valid && opcode == OpSto);
  assign step_seen_d = (retire ? 1'b0 : step_seen_q) | step;
  assign fetch_go    = step_seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_seen_q <= 1'b0;
    end else begin
      step_seen_q <= step_seen_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    status_d      = status_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    acc_we        = 1'b0;
    acc_sel       = AccSelAlu;
    alu_operation = 1'b0;
    alu_op2_sel   = 1'b0;
    halted        = 1'b0;

    case (state_q)
      StRstWait: state_d = StFetch;

      StFetch: begin
        if (fetch_go) begin
          imem_req = 1'b1;
          if (imem_valid) begin
            ir_d    = imem_data;
            state_d = StDecode;
          end
        end
      end

      StDecode: begin
        if (is_mem_op(opcode)) begin
          state_d = StMem;
        end else if (opcode == OpHlt) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end

      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OpSto);
        if (dmem_valid) begin
          if (opcode == OpSto) begin
            pc_d    = pc_q + PcOne;
            state_d = StFetch;
          end else begin
            state_d = StExec;
          end
        end
      end

      StExec: begin
        if (opcode == OpLd) begin
          acc_we  = 1'b1;
          acc_sel = AccSelMem;
        end else if (opcode == OpLdi) begin
          acc_we  = 1'b1;
          acc_sel = AccSelImm;
        end else if (is_arith(opcode)) begin
          acc_we        = 1'b1;
          acc_sel       = AccSelAlu;
          alu_operation = opcode inside {OpSub, OpSubi};
          alu_op2_sel   = opcode inside {OpAddi, OpSubi};
          status_d      = {alu_n, alu_z};
        end
        // taken is only ever set for branch opcodes
        pc_d    = taken ? operand_w : pc_q + PcOne;
        state_d = StFetch;
      end

      StHalt: halted = 1'b1;

      default: state_d = StRstWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRstWait;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_bip2_control_unit.sv
// Bench for bip2_control_unit: ISA-level model checked at every fetch, plus directed cases.
module tb_bip2_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_valid;
  logic [10:0] imem_addr;
  logic [15:0] imem_data;
  logic        dmem_req, dmem_we, dmem_valid;
  logic [10:0] dmem_addr, dmem_rdata, operand;
  logic        alu_operation, alu_op2_sel, alu_z, alu_n, acc_we, halted;
  logic [1:0]  acc_sel, status;
`ifdef BIP2_STEP_EN
  logic        step = 1'b1;
`endif

  always #5 clk = ~clk;

  bip2_control_unit dut (
`ifdef BIP2_STEP_EN
    .step          (step),
`endif
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_valid    (dmem_valid),
    .operand       (operand),
    .alu_operation (alu_operation),
    .alu_op2_sel   (alu_op2_sel),
    .alu_z         (alu_z),
    .alu_n         (alu_n),
    .acc_we        (acc_we),
    .acc_sel       (acc_sel),
    .status        (status),
    .halted        (halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Datapath around the control unit: ACC, memory-data latch and ALU.
  logic [10:0] acc, mdr, op2, alu_res;
  assign op2     = alu_op2_sel ? operand : mdr;
  assign alu_res = alu_operation ? acc - op2 : acc + op2;
  assign alu_z   = (alu_res == 11'd0);
  assign alu_n   = alu_res[10];

  always @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mdr <= '0;
    end else begin
      if (dmem_req && dmem_valid && !dmem_we) mdr <= dmem_rdata;
      if (acc_we) begin
        case (acc_sel)
          2'b00:   acc <= alu_res;
          2'b01:   acc <= mdr;
          2'b10:   acc <= operand;
          default: acc <= acc;
        endcase
      end
    end
  end

  // Memories and the architectural reference model.
  logic [15:0] imem  [2048];
  logic [10:0] b_mem [2048];
  logic [10:0] m_mem [2048];
  logic [10:0] m_pc, m_acc;
  logic [1:0]  m_st;
  logic        m_halt;
  logic [10:0] last_faddr;
  int          n_fetch = 0;
  int          n_accwe = 0;
  int          i_lat = 0, d_lat = 0;

  task automatic mdl_exec(input logic [15:0] ins);
    logic [4:0]  opc;
    logic [10:0] opd, src, r;
    logic        z, n, take;
    opc  = ins[15:11];
    opd  = ins[10:0];
    z    = m_st[0];
    n    = m_st[1];
    take = 1'b0;
    case (opc)
      5'd0: m_halt = 1'b1;
      5'd1: m_mem[opd] = m_acc;
      5'd2: m_acc = m_mem[opd];
      5'd3: m_acc = opd;
      5'd4, 5'd5, 5'd6, 5'd7: begin
        src   = (opc == 5'd5 || opc == 5'd7) ? opd : m_mem[opd];
        r     = (opc >= 5'd6) ? m_acc - src : m_acc + src;
        m_st  = {r[10], r == 11'd0};
        m_acc = r;
      end
      5'd8:  take = z;
      5'd9:  take = !z;
      5'd10: take = !z && !n;
      5'd11: take = !n;
      5'd12: take = n;
      5'd13: take = n || z;
      5'd14: take = 1'b1;
      default: take = 1'b0;
    endcase
    if (opc != 5'd0) m_pc = take ? opd : m_pc + 11'd1;
  endtask

  task automatic on_fetch();
    n_fetch++;
    last_faddr = imem_addr;
    if (m_halt) check_eq("fetch_after_hlt", {31'b0, imem_req}, 32'd0);
    check_eq("fetch_addr", {21'b0, imem_addr}, {21'b0, m_pc});
    check_eq("fetch_status", {30'b0, status}, {30'b0, m_st});
    check_eq("fetch_acc", {21'b0, acc}, {21'b0, m_acc});
    mdl_exec(imem_data);
  endtask

  initial begin
    bit i_busy = 0;
    int i_w = 0;
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (rst) begin
        i_busy = 0;
      end else if (imem_req) begin
        if (!i_busy) begin
          i_busy = 1;
          i_w    = (i_lat < 0) ? int'($urandom_range(0, 3)) : i_lat;
        end
        if (i_w == 0) begin
          i_busy     = 0;
          imem_valid = 1'b1;
          imem_data  = imem[imem_addr];
          on_fetch();
        end else begin
          i_w--;
        end
      end
    end
  end

  initial begin
    bit d_busy = 0;
    int d_w = 0;
    dmem_valid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_valid = 1'b0;
      if (acc_we && !rst) n_accwe++;
      if (rst) begin
        d_busy = 0;
      end else if (dmem_req) begin
        if (!d_busy) begin
          d_busy = 1;
          d_w    = (d_lat < 0) ? int'($urandom_range(0, 3)) : d_lat;
        end
        if (d_w == 0) begin
          d_busy     = 0;
          dmem_valid = 1'b1;
          if (dmem_we) b_mem[dmem_addr] = acc;
          else         dmem_rdata = b_mem[dmem_addr];
        end else begin
          d_w--;
        end
      end
    end
  end

  task automatic init_mem();
    for (int a = 0; a < 2048; a++) begin
      imem[a]  = 16'hF800;  // NOP
      b_mem[a] = 11'($urandom);
      m_mem[a] = b_mem[a];
    end
  endtask

  // Returns just after the reset edge, with the DUT sitting in its post-reset wait state.
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    m_pc = '0; m_acc = '0; m_st = '0; m_halt = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic finish_prog(input int budget);
    int nd = 0;
    for (int c = 0; c < budget && !halted; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_eq("halted", {31'b0, halted}, {31'b0, m_halt});
    if (m_halt) begin
      check_eq("end_acc", {21'b0, acc}, {21'b0, m_acc});
      check_eq("end_status", {30'b0, status}, {30'b0, m_st});
      check_eq("halt_no_req", {30'b0, imem_req, dmem_req}, 32'd0);
      for (int a = 0; a < 2048; a++) if (b_mem[a] !== m_mem[a]) nd++;
      check_eq("dmem_image", nd, 0);
    end
  endtask

  task automatic wait_dmem_req(input int budget);
    for (int c = 0; c < budget && !dmem_req; c++) @(negedge clk);
    check_eq("dmem_req_seen", {31'b0, dmem_req}, 32'd1);
  endtask

  initial begin
    int held, nf, acc0, reqcnt;
    logic [4:0] opc;

    // LDI 5; ADDI 3; HLT with zero-wait memories
    i_lat = 0; d_lat = 0;
    init_mem();
    imem[0] = {5'd3, 11'd5};
    imem[1] = {5'd5, 11'd3};
    imem[2] = {5'd0, 11'd0};
    do_reset();
    check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check_eq("rst_acc_we", {31'b0, acc_we}, 32'd0);
    check_eq("rst_halted", {31'b0, halted}, 32'd0);
    check_eq("rst_status", {30'b0, status}, 32'd0);
    check_eq("rst_imem_addr", {21'b0, imem_addr}, 32'd0);
    repeat (8) @(posedge clk);
    #1 check_eq("halted_at_8", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #1 check_eq("halted_at_9", {31'b0, halted}, 32'd1);
    check_eq("ldi_addi_acc", {21'b0, acc}, 32'd8);
    finish_prog(10);

    // LDI 3; SUBI 3; BEQ 0x040
    init_mem();
    imem[0] = {5'd3, 11'd3};
    imem[1] = {5'd7, 11'd3};
    imem[2] = {5'd8, 11'h040};
    imem[11'h040] = 16'h0000;
    do_reset();
    finish_prog(40);
    check_eq("beq_status", {30'b0, status}, 32'd1);
    check_eq("beq_target", {21'b0, last_faddr}, 32'h040);

    // LDI 2; SUBI 3 -> 0x7FF; BLT taken; BGE not taken
    init_mem();
    imem[0] = {5'd3, 11'd2};
    imem[1] = {5'd7, 11'd3};
    imem[2] = {5'd12, 11'h010};
    imem[11'h010] = {5'd11, 11'h300};
    imem[11'h011] = 16'h0000;
    do_reset();
    finish_prog(40);
    check_eq("neg_status", {30'b0, status}, 32'd2);
    check_eq("neg_acc", {21'b0, acc}, 32'h7FF);
    check_eq("bge_fallthru", {21'b0, last_faddr}, 32'h011);

    // STO 0x100 with a 4-cycle data-memory delay
    init_mem();
    imem[0] = {5'd3, 11'h055};
    imem[1] = {5'd1, 11'h100};
    imem[2] = 16'h0000;
    d_lat = 4;
    do_reset();
    wait_dmem_req(20);
    acc0 = n_accwe;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      if (dmem_req && dmem_we && dmem_addr == 11'h100) held++;
      else if (held > 0) break;
      @(negedge clk);
    end
    check_eq("sto_hold", held, 5);
    check_eq("sto_no_acc_we", n_accwe - acc0, 0);
    finish_prog(20);
    check_eq("sto_data", {21'b0, b_mem[11'h100]}, 32'h055);

    // PC wrap: JMP 0x7FF, NOP at 0x7FF, next fetch from 0
    init_mem();
    imem[0] = {5'd14, 11'h7FF};
    d_lat = 0;
    do_reset();
    nf = n_fetch;
    for (int c = 0; c < 30 && n_fetch - nf < 3; c++) @(posedge clk);
    #1 check_eq("wrap_fetches", n_fetch - nf, 3);
    check_eq("wrap_addr", {21'b0, last_faddr}, 32'h000);

    // Reset while a store is waiting in MEM
    init_mem();
    imem[0] = {5'd1, 11'h100};
    d_lat = 30;
    do_reset();
    wait_dmem_req(20);
    do_reset();
    check_eq("rst_mem_dmem_req", {31'b0, dmem_req}, 32'd0);
    check_eq("rst_mem_wait", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #1 check_eq("rst_mem_fetch", {31'b0, imem_req}, 32'd1);
    check_eq("rst_mem_pc", {21'b0, imem_addr}, 32'd0);

`ifdef BIP2_STEP_EN
    // Single-step: idle without step, exactly one instruction per pulse
    init_mem();
    d_lat = 0;
    step = 1'b0;
    do_reset();
    reqcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req) reqcnt++;
    end
    check_eq("step_idle_req", reqcnt, 0);
    nf = n_fetch;
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (20) @(posedge clk);
    #1 check_eq("step_one_instr", n_fetch - nf, 1);
    step = 1'b1;
`endif

    // Random programs with random memory latencies
    for (int p = 0; p < 6; p++) begin
      init_mem();
      for (int a = 0; a < 2048; a++) begin
        held = int'($urandom_range(0, 99));
        if (held < 2)       opc = 5'd0;
        else if (held < 90) opc = 5'($urandom_range(1, 14));
        else                opc = 5'($urandom_range(15, 31));
        imem[a] = {opc, 11'($urandom)};
      end
      i_lat = -1; d_lat = -1;
      do_reset();
      finish_prog(1500);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
